// File: rtl/marble_launcher.sv
// Marble sequencer for a Turing Tumble board: releases one marble at a time,
// follows the bottom lever/interceptor events and halts with a reason code.
module marble_launcher #(
  parameter int CNT_W     = 4,
  parameter int BLUE_INIT = 8,
  parameter int RED_INIT  = 8,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load,
  input  logic             i_trig_left,
  input  logic             i_trig_right,
  input  logic             i_intercept,
  output logic             o_blue,
  output logic             o_red,
  output logic             busy,
  output logic [1:0]       halt_reason,
  output logic [CNT_W-1:0] blue_left,
  output logic [CNT_W-1:0] red_left,
  output logic [CNT_W-1:0] collected
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_FLIGHT,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    HR_NONE      = 2'd0,
    HR_INTERCEPT = 2'd1,
    HR_EMPTY     = 2'd2,
    HR_TIMEOUT   = 2'd3
  } reason_t;

  localparam logic [CNT_W-1:0] L_BLUE_INIT = CNT_W'(BLUE_INIT);
  localparam logic [CNT_W-1:0] L_RED_INIT  = CNT_W'(RED_INIT);
  localparam logic [TO_W-1:0]  L_TIMEOUT   = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);
  localparam logic [TO_W-1:0]  L_WD_ONE    = TO_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_color;      // 0 = blue, 1 = red
  reason_t          r_reason;
  logic [CNT_W-1:0] r_blue;
  logic [CNT_W-1:0] r_red;
  logic [CNT_W-1:0] r_coll;
  logic [TO_W-1:0]  r_wd;

  logic             w_reload;
  logic             w_halt;
  reason_t          w_halt_code;
  logic             w_color_set;
  logic             w_color_val;
  logic             w_collect;
  logic             w_wd_dec;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    w_halt      = 1'b0;
    w_halt_code = HR_NONE;
    w_color_set = 1'b0;
    w_color_val = 1'b0;
    w_collect   = 1'b0;
    w_wd_dec    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load) begin
          w_reload = 1'b1;
        end else if (start) begin
          if (r_blue != '0) begin
            w_color_set = 1'b1;
            w_color_val = 1'b0;
            w_state_nxt = S_LAUNCH;
          end else begin
            w_halt      = 1'b1;
            w_halt_code = HR_EMPTY;
            w_state_nxt = S_HALT;
          end
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_FLIGHT;
      end
      S_FLIGHT: begin
        // Priority: intercept, then left, then right; any event beats expiry.
        if (i_intercept) begin
          w_halt      = 1'b1;
          w_halt_code = HR_INTERCEPT;
          w_state_nxt = S_HALT;
        end else if (i_trig_left || i_trig_right) begin
          w_collect = 1'b1;
          if ((i_trig_left && r_blue != '0) || (!i_trig_left && r_red != '0)) begin
            w_color_set = 1'b1;
            w_color_val = !i_trig_left;
            w_state_nxt = S_LAUNCH;
          end else begin
            w_halt      = 1'b1;
            w_halt_code = HR_EMPTY;
            w_state_nxt = S_HALT;
          end
        end else if (r_wd == '0) begin
          w_halt      = 1'b1;
          w_halt_code = HR_TIMEOUT;
          w_state_nxt = S_HALT;
        end else begin
          w_wd_dec = 1'b1;
        end
      end
      S_HALT: begin
        if (load) begin
          w_reload    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_color  <= 1'b0;
      r_reason <= HR_NONE;
      r_blue   <= L_BLUE_INIT;
      r_red    <= L_RED_INIT;
      r_coll   <= '0;
      r_wd     <= '0;
    end else begin
      if (w_reload) begin
        r_blue   <= L_BLUE_INIT;
        r_red    <= L_RED_INIT;
        r_coll   <= '0;
        r_reason <= HR_NONE;
      end
      if (w_halt) r_reason <= w_halt_code;
      if (w_color_set) r_color <= w_color_val;
      if (w_collect && r_coll != '1) r_coll <= r_coll + L_ONE;
      if (r_state == S_LAUNCH) begin
        if (r_color) r_red  <= r_red - L_ONE;
        else         r_blue <= r_blue - L_ONE;
        r_wd <= L_TIMEOUT;
      end else if (w_wd_dec) begin
        r_wd <= r_wd - L_WD_ONE;
      end
    end
  end

  assign o_blue      = (r_state == S_LAUNCH) && !r_color;
  assign o_red       = (r_state == S_LAUNCH) &&  r_color;
  assign busy        = (r_state == S_LAUNCH) || (r_state == S_FLIGHT);
  assign halt_reason = r_reason;
  assign blue_left   = r_blue;
  assign red_left    = r_red;
  assign collected   = r_coll;

endmodule

// File: tb/tb_marble_launcher.sv
// Bench for marble_launcher: directed scenarios plus random stimulus, every
// cycle compared against a behavioural model of the launcher rules.
module tb_marble_launcher;

  localparam int CNT_W = 4;
  localparam int BI    = 2;
  localparam int RI    = 15;
  localparam int TO    = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0, start = 1'b0, load = 1'b0;
  logic             tl = 1'b0, tr = 1'b0, ic = 1'b0;
  logic             o_blue, o_red, busy;
  logic [1:0]       halt_reason;
  logic [CNT_W-1:0] blue_left, red_left, collected;

  marble_launcher #(
    .CNT_W(CNT_W), .BLUE_INIT(BI), .RED_INIT(RI), .TIMEOUT(TO), .TO_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .load(load),
    .i_trig_left(tl), .i_trig_right(tr), .i_intercept(ic),
    .o_blue(o_blue), .o_red(o_red), .busy(busy), .halt_reason(halt_reason),
    .blue_left(blue_left), .red_left(red_left), .collected(collected)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: marble in flight / queued release / halted, with plain int counts.
  int m_pulse   = -1;  // -1 none, 0 blue release this cycle, 1 red
  bit m_running = 0;
  bit m_halted  = 0;
  int m_age     = 0;   // completed flight cycles of the current marble
  int m_reason  = 0;
  int m_blue    = BI;
  int m_red     = RI;
  int m_coll    = 0;

  int n_blue_pulses = 0;
  int order[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_halt(input int why);
    m_running = 0;
    m_halted  = 1;
    m_reason  = why;
  endtask

  task automatic reload();
    m_blue = BI; m_red = RI; m_coll = 0; m_reason = 0;
  endtask

  task automatic model(input bit s, input bit l, input bit a, input bit b, input bit c, input bit r);
    int col;
    if (r) begin
      m_pulse = -1; m_running = 0; m_halted = 0; m_age = 0;
      reload();
    end else if (m_pulse >= 0) begin
      if (m_pulse == 0) m_blue--; else m_red--;
      m_pulse = -1;
      m_age   = 0;
    end else if (m_running) begin
      if (c) do_halt(1);
      else if (a || b) begin
        m_coll = (m_coll + 1 > MAXC) ? MAXC : m_coll + 1;
        col = a ? 0 : 1;
        if ((col == 0 ? m_blue : m_red) > 0) m_pulse = col;
        else do_halt(2);
      end else if (m_age == TO) do_halt(3);
      else m_age++;
    end else if (m_halted) begin
      if (l) begin reload(); m_halted = 0; end
    end else begin
      if (l) reload();
      else if (s) begin
        if (m_blue > 0) begin m_pulse = 0; m_running = 1; end
        else do_halt(2);
      end
    end
  endtask

  task automatic step(input bit s, input bit l, input bit a, input bit b, input bit c, input bit r);
    start = s; load = l; tl = a; tr = b; ic = c; rst = r;
    model(s, l, a, b, c, r);
    @(posedge clk);
    #1;
    chk("o_blue",      32'(o_blue),      32'(m_pulse == 0));
    chk("o_red",       32'(o_red),       32'(m_pulse == 1));
    chk("busy",        32'(busy),        32'(m_running));
    chk("halt_reason", 32'(halt_reason), 32'(m_reason));
    chk("blue_left",   32'(blue_left),   32'(m_blue));
    chk("red_left",    32'(red_left),    32'(m_red));
    chk("collected",   32'(collected),   32'(m_coll));
    if (o_blue) begin n_blue_pulses++; order.push_back(0); end
    if (o_red) order.push_back(1);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // k quiet flight cycles, then the given event at the end of flight cycle k.
  task automatic fly(input int k, input bit a, input bit b, input bit c);
    for (int i = 0; i < k; i++) idle_step();
    step(0, 0, a, b, c, 0);
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_blue", 32'(blue_left), BI);
    chk("rst_coll", 32'(collected), 0);

    // Normal run and blue exhaustion
    n_blue_pulses = 0;
    step(1, 0, 0, 0, 0, 0);
    chk("start_pulse", 32'(o_blue), 1);
    fly(2, 1, 0, 0);
    fly(2, 1, 0, 0);
    chk("exh_pulses", 32'(n_blue_pulses), 2);
    chk("exh_reason", 32'(halt_reason), 2);
    chk("exh_coll",   32'(collected), 2);
    chk("exh_blue",   32'(blue_left), 0);
    chk("exh_red",    32'(red_left), RI);

    // Load from HALT after an empty halt
    step(0, 1, 0, 0, 0, 0);
    chk("ld_reason", 32'(halt_reason), 0);
    chk("ld_blue",   32'(blue_left), BI);
    chk("ld_red",    32'(red_left), RI);
    chk("ld_coll",   32'(collected), 0);
    idle_step();
    chk("ld_idle_busy", 32'(busy), 0);

    // Colour alternation
    order.delete();
    step(1, 0, 0, 0, 0, 0);
    fly(1, 0, 1, 0);
    fly(2, 1, 0, 0);
    fly(1, 0, 1, 0);
    fly(1, 1, 0, 0);
    chk("alt_len", 32'(order.size()), 4);
    if (order.size() == 4) begin
      chk("alt_0", 32'(order[0]), 0);
      chk("alt_1", 32'(order[1]), 1);
      chk("alt_2", 32'(order[2]), 0);
      chk("alt_3", 32'(order[3]), 1);
    end
    chk("alt_reason", 32'(halt_reason), 2);
    chk("alt_coll",   32'(collected), 4);

    // Simultaneous events: intercept wins
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    fly(1, 1, 1, 1);
    chk("sim_reason", 32'(halt_reason), 1);
    chk("sim_coll",   32'(collected), 0);
    idle_step();
    idle_step();
    // Left and right together: left wins
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    fly(2, 1, 1, 0);
    chk("lr_blue", 32'(o_blue), 1);
    chk("lr_red",  32'(o_red), 0);

    // Watchdog expiry: 4 flight cycles then HALT
    for (int i = 0; i < 4; i++) idle_step();
    chk("wd_busy4", 32'(busy), 1);
    idle_step();
    chk("wd_reason", 32'(halt_reason), 3);
    chk("wd_busy",   32'(busy), 0);
    // Trigger on the 4th flight cycle beats expiry
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    fly(4, 1, 0, 0);
    chk("wd_trig_blue", 32'(o_blue), 1);
    chk("wd_trig_reason", 32'(halt_reason), 0);

    // Reset mid-flight
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    idle_step();
    idle_step();
    step(0, 0, 0, 0, 0, 1);
    chk("rmf_blue_pulse", 32'(o_blue), 0);
    chk("rmf_busy", 32'(busy), 0);
    chk("rmf_blue", 32'(blue_left), BI);
    // Load beats start in IDLE
    step(1, 1, 0, 0, 0, 0);
    chk("ldst_busy", 32'(busy), 0);
    idle_step();
    chk("ldst_busy2", 32'(busy), 0);

    // Collected saturation: 16 returns on a 4-bit counter
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      idle_step();
      step(0, 0, 0, 1, 0, 0);
    end
    chk("sat_coll",   32'(collected), MAXC);
    chk("sat_reason", 32'(halt_reason), 2);
    chk("sat_red",    32'(red_left), 0);

    // Randomised stimulus
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) == 0, $urandom_range(24) == 0,
           $urandom_range(5) == 0, $urandom_range(5) == 0,
           $urandom_range(29) == 0, $urandom_range(299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
